// File: rtl/router_pkg.sv
// Shared types and constants for the router control path.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter bounding how long the FSM may sit in WAIT_TILL_EMPTY.
module router_wait_timer #(
    parameter int LIMIT = 32
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_r;

    // Count while enabled, restart whenever the FSM leaves the wait state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/router_fsm.sv
// Router write-side sequencer. Define ROUTER_FSM_TIMEOUT_EN to bound
// WAIT_TILL_EMPTY by TIMEOUT_CYCLES and emit a one-cycle timeout pulse.
module router_fsm
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 timeout
);

    router_state_e     state_r;
    router_state_e     fsm_next_s;
    router_state_e     next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic              soft_hit_s;
    logic              timer_expired_s;

    logic write_enb_s, detect_add_s, lfd_s, ld_s, laf_s, full_s, rst_int_s, busy_s;
    logic write_enb_r, detect_add_r, lfd_r, ld_r, laf_r, full_r, rst_int_r, busy_r;

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic in_wait_s;
    logic timeout_r;

    assign in_wait_s = (state_r == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .enable  (in_wait_s),
        .clear   (!in_wait_s),
        .expired (timer_expired_s)
    );

    // The pulse lines up with the first DECODE_ADDRESS cycle after expiry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timer_expired_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timer_expired_s = 1'b0;
    assign timeout         = 1'b0;
`endif

    // Per-state transition rules, before the soft-reset override.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != ADDR_INVALID)) begin
                    if (fifo_empty[data_in]) fsm_next_s = LOAD_FIRST_DATA;
                    else                     fsm_next_s = WAIT_TILL_EMPTY;
                end else begin
                    fsm_next_s = DECODE_ADDRESS;
                end
            end
            LOAD_FIRST_DATA: fsm_next_s = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       fsm_next_s = FIFO_FULL_STATE;
                else if (!pkt_valid) fsm_next_s = LOAD_PARITY;
                else                 fsm_next_s = LOAD_DATA;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) fsm_next_s = LOAD_AFTER_FULL;
                else            fsm_next_s = FIFO_FULL_STATE;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        fsm_next_s = DECODE_ADDRESS;
                else if (low_pkt_valid) fsm_next_s = LOAD_PARITY;
                else                    fsm_next_s = LOAD_DATA;
            end
            LOAD_PARITY: fsm_next_s = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full) fsm_next_s = FIFO_FULL_STATE;
                else           fsm_next_s = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[addr_r])   fsm_next_s = LOAD_FIRST_DATA;
                else if (timer_expired_s) fsm_next_s = DECODE_ADDRESS;
                else                      fsm_next_s = WAIT_TILL_EMPTY;
            end
            default: fsm_next_s = DECODE_ADDRESS;
        endcase
    end

    assign soft_hit_s   = (state_r != DECODE_ADDRESS) && soft_reset[addr_r];
    assign next_state_s = soft_hit_s ? DECODE_ADDRESS : fsm_next_s;

    // State register and destination latch, captured as the header is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= DECODE_ADDRESS;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if ((state_r == DECODE_ADDRESS) && (next_state_s != DECODE_ADDRESS)) begin
                addr_r <= data_in;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Decode the upcoming state so the registered strobes track state_r exactly.
    always_comb begin
        write_enb_s  = 1'b0;
        detect_add_s = 1'b0;
        lfd_s        = 1'b0;
        ld_s         = 1'b0;
        laf_s        = 1'b0;
        full_s       = 1'b0;
        rst_int_s    = 1'b0;
        busy_s       = 1'b1;
        case (next_state_s)
            DECODE_ADDRESS:     begin detect_add_s = 1'b1; busy_s = 1'b0; end
            LOAD_FIRST_DATA:    lfd_s = 1'b1;
            LOAD_DATA:          begin ld_s = 1'b1; write_enb_s = 1'b1; busy_s = 1'b0; end
            FIFO_FULL_STATE:    full_s = 1'b1;
            LOAD_AFTER_FULL:    begin laf_s = 1'b1; write_enb_s = 1'b1; end
            LOAD_PARITY:        write_enb_s = 1'b1;
            CHECK_PARITY_ERROR: rst_int_s = 1'b1;
            WAIT_TILL_EMPTY:    busy_s = 1'b1;
            default:            begin detect_add_s = 1'b1; busy_s = 1'b0; end
        endcase
    end

    // Output strobe registers; reset presents the DECODE_ADDRESS pattern.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write_enb_r  <= 1'b0;
            detect_add_r <= 1'b1;
            lfd_r        <= 1'b0;
            ld_r         <= 1'b0;
            laf_r        <= 1'b0;
            full_r       <= 1'b0;
            rst_int_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            write_enb_r  <= write_enb_s;
            detect_add_r <= detect_add_s;
            lfd_r        <= lfd_s;
            ld_r         <= ld_s;
            laf_r        <= laf_s;
            full_r       <= full_s;
            rst_int_r    <= rst_int_s;
            busy_r       <= busy_s;
        end
    end

    assign write_enb_reg = write_enb_r;
    assign detect_add    = detect_add_r;
    assign lfd_state     = lfd_r;
    assign ld_state      = ld_r;
    assign laf_state     = laf_r;
    assign full_state    = full_r;
    assign rst_int_reg   = rst_int_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_router_fsm.sv
// Directed scoreboard bench for router_fsm (default or ROUTER_FSM_TIMEOUT_EN build).
module tb_router_fsm;

    // Output word: {write_enb_reg, detect_add, lfd, ld, laf, full, rst_int_reg, busy, timeout}
    localparam logic [8:0] E_DA   = 9'b0_1_0_0_0_0_0_0_0;
    localparam logic [8:0] E_LFD  = 9'b0_0_1_0_0_0_0_1_0;
    localparam logic [8:0] E_LD   = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] E_FULL = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] E_LAF  = 9'b1_0_0_0_1_0_0_1_0;
    localparam logic [8:0] E_LP   = 9'b1_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_CPE  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] E_WTE  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_TO   = 9'b0_0_0_0_0_0_0_0_1;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy, timeout;

    logic [8:0] exp_q[$];
    int         total_checks  = 0;
    int         passed_checks = 0;

    router_fsm #(.TIMEOUT_CYCLES(8)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    task automatic check_out(input string tag);
        logic [8:0] obs;
        logic [8:0] expd;
        obs  = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                full_state, rst_int_reg, busy, timeout};
        expd = exp_q.pop_front();
        total_checks++;
        assert (obs === expd) begin
            passed_checks++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, expd);
        end
    endtask

    task automatic expect_next(input logic [8:0] expd, input string tag);
        exp_q.push_back(expd);
        @(posedge clock);
        #1;
        check_out(tag);
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        #12;
        exp_q.push_back(E_DA);
        check_out("reset_state");
        @(posedge clock); #1;
        resetn = 1'b1;
        expect_next(E_DA, "idle_hold");

        // Normal packet to port 1
        pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b111;
        expect_next(E_LFD, "a_lfd");
        expect_next(E_LD,  "a_ld1");
        expect_next(E_LD,  "a_ld2");
        expect_next(E_LD,  "a_ld3");
        pkt_valid = 1'b0;
        expect_next(E_LP,  "a_lp");
        expect_next(E_CPE, "a_cpe");
        expect_next(E_DA,  "a_da");

        // Port 2 busy: wait on the latched address, not on data_in
        pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
        expect_next(E_WTE, "b_wait0");
        data_in = 2'b00;
        for (int i = 1; i < 5; i++) expect_next(E_WTE, "b_wait");
        fifo_empty = 3'b111;
        expect_next(E_LFD, "b_lfd");
        expect_next(E_LD,  "b_ld");
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) expect_next(E_FULL, "b_full");
        fifo_full = 1'b0;
        expect_next(E_LAF, "b_laf");
        expect_next(E_LD,  "b_laf_to_ld");
        pkt_valid = 1'b0; fifo_full = 1'b1;
        expect_next(E_FULL, "b_full_prio");
        fifo_full = 1'b0;
        expect_next(E_LAF, "b_laf2");
        low_pkt_valid = 1'b1;
        expect_next(E_LP,  "b_laf_to_lp");
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        expect_next(E_CPE, "b_cpe");
        expect_next(E_FULL, "b_cpe_to_full");
        fifo_full = 1'b0; parity_done = 1'b1;
        expect_next(E_LAF, "b_laf3");
        expect_next(E_DA,  "b_laf_to_da");
        parity_done = 1'b0;

        // Soft reset selected by latched address 0
        pkt_valid = 1'b1; data_in = 2'b00;
        expect_next(E_LFD, "c_lfd");
        expect_next(E_LD,  "c_ld");
        soft_reset = 3'b100;
        expect_next(E_LD,  "c_sr_other");
        soft_reset = 3'b001;
        expect_next(E_DA,  "c_sr_hit");
        soft_reset = 3'b000;

        // Invalid address ignored, then reset mid-packet
        data_in = 2'b11;
        expect_next(E_DA,  "d_invalid1");
        expect_next(E_DA,  "d_invalid2");
        data_in = 2'b01;
        expect_next(E_LFD, "d_lfd");
        expect_next(E_LD,  "d_ld");
        #3;
        resetn = 1'b0;
        #1;
        exp_q.push_back(E_DA);
        check_out("d_async_reset");
        @(posedge clock); #1;
        exp_q.push_back(E_DA);
        check_out("d_in_reset");
        resetn = 1'b1; pkt_valid = 1'b0;
        expect_next(E_DA,  "d_after_reset");

        // Long wait on port 1
        pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b101;
        expect_next(E_WTE, "e_wait0");
`ifdef ROUTER_FSM_TIMEOUT_EN
        for (int i = 1; i < 8; i++) expect_next(E_WTE, "e_wait");
        pkt_valid = 1'b0;
        expect_next(E_DA | E_TO, "e_timeout_pulse");
        expect_next(E_DA, "e_timeout_done");
`else
        for (int i = 1; i < 20; i++) expect_next(E_WTE, "e_wait_forever");
        soft_reset = 3'b010;
        expect_next(E_DA, "e_sr_wait");
        soft_reset = 3'b000; pkt_valid = 1'b0;
        expect_next(E_DA, "e_idle");
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: WAIT_TILL_EMPTY cycle limit (only with ROUTER_FSM_TIMEOUT_EN).
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 pkt_valid  in  1  source packet-valid.
REQ-005 data_in  in  2  destination address bits [1:0] of the header byte.
REQ-006 fifo_full  in  1  full flag of the currently addressed output FIFO.
REQ-007 fifo_empty  in  3  per-port empty flags; bit n is FIFO n.
REQ-008 soft_reset  in  3  per-port soft-reset pulses from the read side.
REQ-009 parity_done, low_pkt_valid  in  1 each  status from the register block.
REQ-010 write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  datapath sequencing strobes.
REQ-011 busy  out  1  back-pressure to the source.
REQ-012 timeout  out  1  one-cycle packet-drop pulse (macro only; tied 0 otherwise).

Function
REQ-013 States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-014 DECODE_ADDRESS: pkt_valid && data_in!=2'b11 && fifo_empty[data_in] -> LOAD_FIRST_DATA; pkt_valid && data_in!=2'b11 && !fifo_empty[data_in] -> WAIT_TILL_EMPTY; otherwise hold.
REQ-015 On leaving DECODE_ADDRESS, data_in SHALL be latched into a 2-bit addr register, used for all later fifo_empty/soft_reset selection.
REQ-016 Address 2'b11 SHALL be ignored: stay in DECODE_ADDRESS, no strobes other than detect_add.
REQ-017 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-018 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else hold; fifo_full has priority.
REQ-019 FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else hold.
REQ-020 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-021 LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-022 WAIT_TILL_EMPTY: fifo_empty[addr] -> LOAD_FIRST_DATA; else hold.
REQ-023 soft_reset[addr] high in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding every other transition.
REQ-024 Outputs SHALL be Moore, decoded from the state register only (one-cycle delay after transition edge).
REQ-025 detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-026 write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
REQ-027 busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-028 Exactly one state strobe (detect_add..rst_int_reg, or none for LOAD_PARITY/WAIT_TILL_EMPTY) SHALL be high per cycle.

Reset
REQ-029 resetn low SHALL asynchronously set state=DECODE_ADDRESS, addr=0, timer=0.
REQ-030 During and after reset: detect_add=1, all other outputs 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; no strobe may glitch high on deassertion.

Configuration
REQ-032 Macro ROUTER_FSM_TIMEOUT_EN defined: counter increments each cycle in WAIT_TILL_EMPTY, clears on any other state; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to DECODE_ADDRESS and pulse timeout for one cycle.
REQ-033 Macro undefined: no counter, WAIT_TILL_EMPTY waits indefinitely, timeout tied 0.

Structure
REQ-034 Shared package router_pkg SHALL hold the state enum, NUM_PORTS=3, ADDR_W=2, ADDR_INVALID=2'b11.
REQ-035 Timeout counter SHALL be sub-module router_wait_timer (clock, resetn, enable, clear, expired), instantiated only under the macro.

Verification
REQ-036 Header data_in=2'b01, fifo_empty=3'b111, pkt_valid 4 cycles then low -> DECODE, LFD, LD x3, LP, CPE, DECODE; write_enb_reg high 4 cycles.
REQ-037 Header addr 2'b10, fifo_empty=3'b011 for 5 cycles then 3'b111 -> WAIT_TILL_EMPTY 5 cycles, busy=1 throughout, then LFD.
REQ-038 fifo_full=1 for 3 cycles during LOAD_DATA -> full_state 3 cycles, then laf_state 1 cycle, back to ld_state; busy high from full through laf.
REQ-039 soft_reset=3'b001 with addr=0 during LOAD_DATA -> detect_add next cycle; soft_reset=3'b100 with addr=0 -> no effect.
REQ-040 Header data_in=2'b11 with pkt_valid=1 -> detect_add stays 1, busy 0; resetn low mid-LOAD_DATA -> detect_add=1 immediately.
REQ-041 Macro on, TIMEOUT_CYCLES=8, fifo_empty[addr] held 0 -> timeout pulses once after 8 cycles, state DECODE_ADDRESS.
